// File: rtl/p18_vga_timing_if.sv
// Beam-timing bundle from the p18 timing generator to the painter stages.
// The generator drives every signal. Painters only read them.
interface p18_vga_timing_if;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [8:0] vpos;
  logic       line_end;
  logic       frame_end;

  modport master (
    output hsync, vsync, display_on, hpos, vpos, line_end, frame_end
  );

  modport slave (
    input  hsync, vsync, display_on, hpos, vpos, line_end, frame_end
  );
endinterface

// File: rtl/p18_vga_timing.sv
// Free-running VGA pixel-timing generator (default 640x480@60, 800x525 totals).
// Every output is registered from the next-state counters, so all outputs describe the same pixel.
module p18_vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0,
  parameter int PIX_DIV   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  p18_vga_timing_if.master  vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [1:0] DIV_LAST = 2'(PIX_DIV - 1);
  localparam logic       SYNC_ACT = (SYNC_POL != 0);

  logic [1:0] div, div_nxt;
  logic [9:0] hpos, hpos_nxt;
  logic [9:0] vcnt, vcnt_nxt;
  logic       tick;
  logic       hsync, hsync_nxt;
  logic       vsync, vsync_nxt;
  logic       display_on, display_on_nxt;
  logic       line_end, line_end_nxt;
  logic       frame_end, frame_end_nxt;

  always_comb begin
    tick     = (div == DIV_LAST);
    div_nxt  = tick ? 2'd0 : div + 2'd1;
    hpos_nxt = hpos;
    vcnt_nxt = vcnt;
    if (tick) begin
      if (hpos == H_LAST) begin
        hpos_nxt = '0;
        vcnt_nxt = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
        hpos_nxt = hpos + 10'd1;
      end
    end

    // Flags are decoded from the next counters so they land in the same cycle as hpos/vpos.
    hsync_nxt      = ((hpos_nxt >= HS_START) && (hpos_nxt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_nxt      = ((vcnt_nxt >= VS_START) && (vcnt_nxt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
    display_on_nxt = (hpos_nxt < H_VIS) && (vcnt_nxt < V_VIS);
    line_end_nxt   = (hpos_nxt == H_LAST) && (div_nxt == DIV_LAST);
    frame_end_nxt  = line_end_nxt && (vcnt_nxt == V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div        <= '0;
      hpos       <= '0;
      vcnt       <= '0;
      hsync      <= ~SYNC_ACT;
      vsync      <= ~SYNC_ACT;
      display_on <= 1'b1;
      line_end   <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      div        <= div_nxt;
      hpos       <= hpos_nxt;
      vcnt       <= vcnt_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
      display_on <= display_on_nxt;
      line_end   <= line_end_nxt;
      frame_end  <= frame_end_nxt;
    end
  end

  // vpos deliberately aliases above line 511; painters gate with display_on.
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.display_on = display_on;
  assign vga.hpos       = hpos;
  assign vga.vpos       = vcnt[8:0];
  assign vga.line_end   = line_end;
  assign vga.frame_end  = frame_end;
endmodule

// File: tb/tb_p18_vga_timing.sv
// Bench for p18_vga_timing: one default-timing instance plus two small-timing instances
// (one with PIX_DIV=2 and active-high sync), checked against an arithmetic beam model.
module tb_p18_vga_timing;
  logic clk;
  logic rst_n;
  logic run;
  int   t;
  int   checks;
  int   passes;

  p18_vga_timing_if ifa ();
  p18_vga_timing_if ifb ();
  p18_vga_timing_if ifc ();

  p18_vga_timing dut_a (.clk(clk), .rst_n(rst_n), .vga(ifa));

  p18_vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(0), .PIX_DIV(1)
  ) dut_b (.clk(clk), .rst_n(rst_n), .vga(ifb));

  p18_vga_timing #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1), .PIX_DIV(2)
  ) dut_c (.clk(clk), .rst_n(rst_n), .vga(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t = clk edges since the last reset release; the model derives everything from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  logic [23:0] pack_a, pack_b, pack_c;
  assign pack_a = {ifa.hsync, ifa.vsync, ifa.display_on, ifa.hpos, ifa.vpos, ifa.line_end, ifa.frame_end};
  assign pack_b = {ifb.hsync, ifb.vsync, ifb.display_on, ifb.hpos, ifb.vpos, ifb.line_end, ifb.frame_end};
  assign pack_c = {ifc.hsync, ifc.vsync, ifc.display_on, ifc.hpos, ifc.vpos, ifc.line_end, ifc.frame_end};

  function automatic logic [23:0] model(input int tt, input int hv, input int hf, input int hs,
                                        input int hb, input int vv, input int vf, input int vs,
                                        input int vb, input int pol, input int dv);
    int   ht, vt, p, h, v;
    logic act, hso, vso, de, le, fe;
    ht  = hv + hf + hs + hb;
    vt  = vv + vf + vs + vb;
    p   = tt / dv;
    h   = p % ht;
    v   = (p / ht) % vt;
    act = (pol != 0);
    hso = (h >= hv + hf && h < hv + hf + hs) ? act : ~act;
    vso = (v >= vv + vf && v < vv + vf + vs) ? act : ~act;
    de  = (h < hv) && (v < vv);
    le  = (h == ht - 1) && ((tt % dv) == dv - 1);
    fe  = le && (v == vt - 1);
    return {hso, vso, de, h[9:0], v[8:0], le, fe};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, act, exp);
    else             passes++;
  endtask

  task automatic wait_t(input int n);
    int guard;
    guard = 0;
    while (t != n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (t != n) chk("wait_timeout", 32'(t), 32'(n));
    #1;
  endtask

  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("model_a", 32'(pack_a), 32'(model(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, 1)));
      chk("model_b", 32'(pack_b), 32'(model(t, 8, 2, 3, 3, 6, 2, 2, 3, 0, 1)));
      chk("model_c", 32'(pack_c), 32'(model(t, 8, 2, 3, 3, 6, 2, 2, 3, 1, 2)));
    end
  end

  // Frame-period monitors, independent of the model.
  int last_b = -1, last_c = -1, per_b = 0, per_c = 0, n_b = 0, n_c = 0;
  always @(negedge clk) begin
    if (run && rst_n) begin
      if (ifb.frame_end) begin
        if (last_b >= 0) per_b = t - last_b;
        last_b = t;
        n_b++;
      end
      if (ifc.frame_end) begin
        if (last_c >= 0) per_c = t - last_c;
        last_c = t;
        n_c++;
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_hpos"}, 32'(ifa.hpos), 0);
    chk({tag, "_a_vpos"}, 32'(ifa.vpos), 0);
    chk({tag, "_a_de"}, 32'(ifa.display_on), 1);
    chk({tag, "_a_hsync"}, 32'(ifa.hsync), 1);
    chk({tag, "_a_vsync"}, 32'(ifa.vsync), 1);
    chk({tag, "_a_le_fe"}, 32'({ifa.line_end, ifa.frame_end}), 0);
    chk({tag, "_b"}, 32'(pack_b), 32'h00E0_0000);
    chk({tag, "_c"}, 32'(pack_c), 32'h0020_0000);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    run    = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
    run = 1'b1;
    #1 chk_reset_vals("rst0");

    wait_t(1);   chk("a_hpos_t1", 32'(ifa.hpos), 1);
    wait_t(30);  chk("c_hold_hpos15", 32'({ifc.hpos, ifc.line_end}), 32'({10'd15, 1'b0}));
    wait_t(31);  chk("c_line_end_t31", 32'({ifc.hpos, ifc.line_end}), 32'({10'd15, 1'b1}));
    wait_t(32);  chk("c_wrap_t32", 32'({ifc.hpos, ifc.vpos, ifc.line_end}), 32'({10'd0, 9'd1, 1'b0}));
    wait_t(127); chk("b_vsync_pre", 32'(ifb.vsync), 1);
    wait_t(128); chk("b_vsync_fall", 32'(ifb.vsync), 0);
    wait_t(159); chk("b_vsync_last", 32'(ifb.vsync), 0);
    wait_t(160); chk("b_vsync_rise", 32'(ifb.vsync), 1);
    wait_t(207); chk("b_frame_end", 32'({ifb.hpos, ifb.vpos, ifb.frame_end}), 32'({10'd15, 9'd12, 1'b1}));
    wait_t(208); chk("b_frame_wrap", 32'({ifb.hpos, ifb.vpos, ifb.frame_end}), 32'({10'd0, 9'd0, 1'b0}));
    wait_t(255); chk("c_vsync_pre", 32'(ifc.vsync), 0);
    wait_t(256); chk("c_vsync_on", 32'(ifc.vsync), 1);
    wait_t(415); chk("c_frame_end", 32'({ifc.hpos, ifc.vpos, ifc.frame_end}), 32'({10'd15, 9'd12, 1'b1}));
    wait_t(416); chk("c_frame_wrap", 32'({ifc.hpos, ifc.frame_end}), 32'({10'd0, 1'b0}));
    wait_t(639); chk("a_de_639", 32'(ifa.display_on), 1);
    wait_t(640); chk("a_de_640", 32'(ifa.display_on), 0);
    wait_t(655); chk("a_hsync_655", 32'(ifa.hsync), 1);
    wait_t(656); chk("a_hsync_656", 32'(ifa.hsync), 0);
    wait_t(751); chk("a_hsync_751", 32'(ifa.hsync), 0);
    wait_t(752); chk("a_hsync_752", 32'(ifa.hsync), 1);
    wait_t(799); chk("a_line_end", 32'({ifa.hpos, ifa.vpos, ifa.line_end}), 32'({10'd799, 9'd0, 1'b1}));
    wait_t(800); chk("a_line_wrap", 32'({ifa.hpos, ifa.vpos, ifa.line_end}), 32'({10'd0, 9'd1, 1'b0}));

    wait_t(1900);
    chk("a_mid_pos", 32'({ifa.hpos, ifa.vpos}), 32'({10'd300, 9'd2}));
    chk("b_period", 32'(per_b), 208);
    chk("c_period", 32'(per_c), 416);
    chk("b_frames", 32'(n_b), 9);
    chk("c_frames", 32'(n_c), 4);

    // Async reset between clock edges must take effect without any edge.
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_mid");
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    #1 chk("a_hpos_rel", 32'(ifa.hpos), 0);
    wait_t(1);    chk("a_hpos_rel_t1", 32'(ifa.hpos), 1);
    wait_t(1000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end, t=%0d", t);
    $fatal(1, "timeout");
  end
endmodule
